// File: rtl/sccb_write_arbiter.sv
// rtl/sccb_write_arbiter.sv - round-robin arbiter sharing one SCCB write controller
// Retries NACKed writes, aborts writes whose END never arrives.
module sccb_write_arbiter #(
  parameter int N_REQ     = 2,
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT   = 1024
) (
  input  logic                iCLK,
  input  logic                iRST_N,
  input  logic [N_REQ-1:0]    iREQ,
  input  logic [24*N_REQ-1:0] iREQ_DATA,
  output logic [N_REQ-1:0]    oDONE,
  output logic [N_REQ-1:0]    oERR,
  output logic                oBUSY,
  output logic [23:0]         oI2C_DATA,
  output logic                oI2C_GO,
  input  logic                iI2C_END,
  input  logic                iI2C_ACK
);

  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT_END, S_RELEASE} state_t;

  state_t           r_state, w_state;
  logic [GW-1:0]    r_last_gnt, w_last_gnt;
  logic [3:0]       r_retry_cnt, w_retry_cnt;
  logic [TW-1:0]    r_tmo_cnt, w_tmo_cnt;
  logic             r_nack, w_nack;
  logic             r_tmo, w_tmo;
  logic [N_REQ-1:0] r_done, w_done;
  logic [N_REQ-1:0] r_err, w_err;
  logic             r_go, w_go;
  logic [23:0]      r_data, w_data;

  logic [N_REQ-1:0] w_req_eff;
  logic             w_any;
  logic [GW-1:0]    w_winner;
  logic [23:0]      w_win_data;
  logic [GW-1:0]    w_idx;
  int               w_sum;

  // The requester just served is masked during its pulse cycle so it
  // cannot be re-granted before it has had a chance to drop iREQ.
  always_comb begin
    w_req_eff = iREQ;
    if (|(r_done | r_err))
      w_req_eff = iREQ & ~(N_REQ'(1) << r_last_gnt);
    w_any      = |w_req_eff;
    w_winner   = r_last_gnt;
    w_win_data = '0;
    w_sum      = 0;
    w_idx      = '0;
    // Scan backwards so the candidate closest after last_gnt is written last.
    for (int i = N_REQ; i >= 1; i--) begin
      w_sum = int'(r_last_gnt) + i;
      if (w_sum >= N_REQ)
        w_sum = w_sum - N_REQ;
      w_idx = w_sum[GW-1:0];
      if (w_req_eff[w_idx]) begin
        w_winner   = w_idx;
        w_win_data = iREQ_DATA[24*w_sum +: 24];
      end
    end
  end

  always_comb begin
    w_state     = r_state;
    w_last_gnt  = r_last_gnt;
    w_retry_cnt = r_retry_cnt;
    w_tmo_cnt   = r_tmo_cnt;
    w_nack      = r_nack;
    w_tmo       = r_tmo;
    w_done      = '0;
    w_err       = '0;
    w_go        = r_go;
    w_data      = r_data;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_data      = w_win_data;
          w_last_gnt  = w_winner;
          w_go        = 1'b1;
          w_retry_cnt = '0;
          w_tmo_cnt   = '0;
          w_state     = S_WAIT_END;
        end
      end
      S_WAIT_END: begin
        if (iI2C_END) begin
          w_go    = 1'b0;
          w_nack  = iI2C_ACK;
          w_tmo   = 1'b0;
          w_state = S_RELEASE;
        end else if (r_tmo_cnt == TW'(TIMEOUT - 1)) begin
          w_go    = 1'b0;
          w_tmo   = 1'b1;
          w_state = S_RELEASE;
        end else begin
          w_tmo_cnt = r_tmo_cnt + TW'(1);
        end
      end
      S_RELEASE: begin
        // The controller must see GO low and drop END before the next GO.
        if (!iI2C_END) begin
          if (r_tmo) begin
            w_err   = N_REQ'(1) << r_last_gnt;
            w_state = S_IDLE;
          end else if (!r_nack) begin
            w_done  = N_REQ'(1) << r_last_gnt;
            w_state = S_IDLE;
          end else if (r_retry_cnt < 4'(MAX_RETRY)) begin
            w_retry_cnt = r_retry_cnt + 4'd1;
            w_tmo_cnt   = '0;
            w_go        = 1'b1;
            w_state     = S_WAIT_END;
          end else begin
            w_err   = N_REQ'(1) << r_last_gnt;
            w_state = S_IDLE;
          end
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state     <= S_IDLE;
      r_last_gnt  <= GW'(N_REQ - 1);
      r_retry_cnt <= '0;
      r_tmo_cnt   <= '0;
      r_nack      <= 1'b0;
      r_tmo       <= 1'b0;
      r_done      <= '0;
      r_err       <= '0;
      r_go        <= 1'b0;
      r_data      <= '0;
    end else begin
      r_state     <= w_state;
      r_last_gnt  <= w_last_gnt;
      r_retry_cnt <= w_retry_cnt;
      r_tmo_cnt   <= w_tmo_cnt;
      r_nack      <= w_nack;
      r_tmo       <= w_tmo;
      r_done      <= w_done;
      r_err       <= w_err;
      r_go        <= w_go;
      r_data      <= w_data;
    end
  end

  assign oDONE     = r_done;
  assign oERR      = r_err;
  assign oBUSY     = (r_state != S_IDLE);
  assign oI2C_GO   = r_go;
  assign oI2C_DATA = r_data;

endmodule

// File: tb/tb_sccb_write_arbiter.sv
// tb/tb_sccb_write_arbiter.sv - directed bench for sccb_write_arbiter
// Behavioural SCCB controller model plus pulse/GO monitor.
module tb_sccb_write_arbiter;

  localparam int NR  = 2;
  localparam int TMO = 16;
  localparam int LAT = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NR-1:0] req;
  logic [47:0]   req_data;
  logic [NR-1:0] done, err;
  logic          busy;
  logic [23:0]   i2c_data;
  logic          go;
  logic          i2c_end = 1'b0;
  logic          i2c_ack = 1'b0;

  sccb_write_arbiter #(.N_REQ(NR), .MAX_RETRY(3), .TIMEOUT(TMO)) dut (
    .iCLK(clk), .iRST_N(rst_n), .iREQ(req), .iREQ_DATA(req_data),
    .oDONE(done), .oERR(err), .oBUSY(busy), .oI2C_DATA(i2c_data),
    .oI2C_GO(go), .iI2C_END(i2c_end), .iI2C_ACK(i2c_ack)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  // Controller model: END after LAT cycles of GO, held until GO drops.
  bit ctl_en    = 1'b1;
  int nack_plan = 0;
  int lat_cnt   = 0;
  int att_idx   = 0;

  always @(posedge clk) begin
    #2;
    if ((|done) || (|err)) att_idx = 0;
    if (!go) begin
      i2c_end = 1'b0;
      i2c_ack = 1'b0;
      lat_cnt = 0;
    end else if (!i2c_end && ctl_en) begin
      lat_cnt++;
      if (lat_cnt == LAT) begin
        i2c_end = 1'b1;
        i2c_ack = (att_idx < nack_plan);
        att_idx++;
        lat_cnt = 0;
      end
    end
  end

  logic [23:0]   data_log [64];
  logic [NR-1:0] done_log [64];
  logic [NR-1:0] err_log  [64];
  int n_rise = 0, n_done = 0, n_err = 0;
  int cyc = 0, fall_cyc = 0, err_cyc = 0, go_run = 0, go_len_last = 0;
  int done_end_bad = 0, n_excl = 0, n_wide = 0;
  bit prev_go = 1'b0, prev_pulse = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (go && !prev_go && n_rise < 64) begin data_log[n_rise] = i2c_data; n_rise++; end
    if (go) go_run++;
    if (!go && prev_go) begin fall_cyc = cyc; go_len_last = go_run; end
    if (!go) go_run = 0;
    if (|done && n_done < 64) begin
      done_log[n_done] = done; n_done++;
      if (i2c_end) done_end_bad++;
    end
    if (|err && n_err < 64) begin err_log[n_err] = err; n_err++; err_cyc = cyc; end
    if ((|done && |err) || $countones(done) > 1 || $countones(err) > 1) n_excl++;
    if ((|(done | err)) && prev_pulse) n_wide++;
    prev_go    = go;
    prev_pulse = |(done | err);
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic wait_pulses(input string tag, input int target, input int budget);
    int b = 0;
    while ((n_done + n_err) < target && b < budget) begin tick; b++; end
    if ((n_done + n_err) < target) check(tag, 32'(n_done + n_err), 32'(target));
  endtask

  int br, bd, be, bp;

  initial begin
    rst_n = 1'b0; req = '0; req_data = '0;
    repeat (3) tick;
    check("rst_go",   32'(go), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_puls", 32'({done, err}), 32'h0);
    check("rst_data", 32'(i2c_data), 32'h0);
    rst_n = 1'b1;
    tick;

    // Round-robin from reset: pointer starts at 1, so requester 0 goes first.
    br = n_rise; bd = n_done;
    req_data = {24'h421181, 24'h421214};
    req = 2'b11;
    wait_pulses("rr_tmo", bd + 4, 400);
    req = 2'b00;
    repeat (3) tick;
    check("rr_rises", 32'(n_rise - br), 32'd4);
    check("rr_d0", 32'(data_log[br]),     32'h421214);
    check("rr_d1", 32'(data_log[br + 1]), 32'h421181);
    check("rr_d2", 32'(data_log[br + 2]), 32'h421214);
    check("rr_d3", 32'(data_log[br + 3]), 32'h421181);
    check("rr_p0", 32'(done_log[bd]),     32'h1);
    check("rr_p1", 32'(done_log[bd + 1]), 32'h2);
    check("rr_p2", 32'(done_log[bd + 2]), 32'h1);
    check("rr_p3", 32'(done_log[bd + 3]), 32'h2);

    // Single write
    bd = n_done; be = n_err;
    req_data[23:0] = 24'h423A04;
    req = 2'b01;
    tick;
    check("t1_go_lat", 32'(go), 32'h1);
    check("t1_data", 32'(i2c_data), 32'h423A04);
    wait_pulses("t1_tmo", n_done + n_err + 1, 100);
    req = 2'b00;
    check("t1_done", 32'(done_log[bd]), 32'h1);
    repeat (3) tick;
    check("t1_ndone", 32'(n_done - bd), 32'd1);
    check("t1_nerr", 32'(n_err - be), 32'd0);
    check("t1_busy", 32'(busy), 32'h0);
    check("t1_end_low", 32'(done_end_bad), 32'd0);

    // Two NACKs then ACK
    br = n_rise; bd = n_done; be = n_err;
    nack_plan = 2;
    req_data[23:0] = 24'h123456;
    req = 2'b01;
    wait_pulses("t3_tmo", n_done + n_err + 1, 300);
    req = 2'b00;
    repeat (3) tick;
    check("t3_rises", 32'(n_rise - br), 32'd3);
    check("t3_dat0", 32'(data_log[br]),     32'h123456);
    check("t3_dat2", 32'(data_log[br + 2]), 32'h123456);
    check("t3_done", 32'(done_log[bd]), 32'h1);
    check("t3_nerr", 32'(n_err - be), 32'd0);

    // Always NACK: 1 + MAX_RETRY attempts then error
    br = n_rise; bd = n_done; be = n_err;
    nack_plan = 99;
    req_data[47:24] = 24'hABCDEF;
    req = 2'b10;
    wait_pulses("t4_tmo", n_done + n_err + 1, 400);
    req = 2'b00;
    repeat (3) tick;
    check("t4_rises", 32'(n_rise - br), 32'd4);
    check("t4_dat3", 32'(data_log[br + 3]), 32'hABCDEF);
    check("t4_err", 32'(err_log[be]), 32'h2);
    check("t4_ndone", 32'(n_done - bd), 32'd0);
    check("t4_busy", 32'(busy), 32'h0);

    // Timeout, then the other pending requester is served
    br = n_rise; bd = n_done; be = n_err;
    nack_plan = 0;
    ctl_en = 1'b0;
    req_data = {24'h00A5A5, 24'h0F0F0F};
    req = 2'b11;
    wait_pulses("t5_tmo", n_done + n_err + 1, 100);
    ctl_en = 1'b1;
    req = 2'b10;
    check("t5_err", 32'(err_log[be]), 32'h1);
    check("t5_golen", 32'(go_len_last), 32'(TMO));
    check("t5_errlat", 32'(err_cyc - fall_cyc), 32'd1);
    check("t5_noretry", 32'(n_rise - br), 32'd1);
    wait_pulses("t5_tmo2", n_done + n_err + 1, 100);
    req = 2'b00;
    check("t5_next_dat", 32'(data_log[br + 1]), 32'h00A5A5);
    check("t5_next_done", 32'(done_log[bd]), 32'h2);

    // Reset mid-transfer
    tick; tick;
    ctl_en = 1'b0;
    req_data[23:0] = 24'h777777;
    req = 2'b01;
    repeat (5) tick;
    check("t6_busy_pre", 32'(busy), 32'h1);
    check("t6_go_pre", 32'(go), 32'h1);
    bp = n_done + n_err;
    rst_n = 1'b0;
    #1;
    check("t6_go_rst", 32'(go), 32'h0);
    check("t6_busy_rst", 32'(busy), 32'h0);
    check("t6_data_rst", 32'(i2c_data), 32'h0);
    tick; tick;
    check("t6_nopulse", 32'(n_done + n_err - bp), 32'd0);
    req_data[47:24] = 24'h5A5A5A;
    req = 2'b10;
    ctl_en = 1'b1;
    rst_n = 1'b1;
    bd = n_done;
    tick;
    check("t6_go", 32'(go), 32'h1);
    check("t6_data", 32'(i2c_data), 32'h5A5A5A);
    wait_pulses("t6_tmo", n_done + n_err + 1, 100);
    req = 2'b00;
    check("t6_done", 32'(done_log[bd]), 32'h2);
    repeat (3) tick;

    check("excl", 32'(n_excl), 32'd0);
    check("width", 32'(n_wide), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
